// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ready handshake,
// loads the IF/ID register and parks one fetched word while decode is stalled.
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_tgt,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_id,
    output logic [15:0] inst_id,
    output logic        valid_id
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_buf_pc, w_buf_pc_nxt;
    logic [15:0] r_buf_inst, w_buf_inst_nxt;
    logic [15:0] r_pc_id, w_pc_id_nxt;
    logic [15:0] r_inst_id, w_inst_id_nxt;
    logic        r_valid_id, w_valid_id_nxt;
    logic        w_accept;

    // Gated by rst_n so no request is seen while reset is held.
    assign imem_addr = r_pc;
    assign imem_req  = rst_n && (r_state == FETCH);
    assign pc_id     = r_pc_id;
    assign inst_id   = r_inst_id;
    assign valid_id  = r_valid_id;

    assign w_accept  = (r_state == FETCH) && imem_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_buf_pc_nxt   = r_buf_pc;
        w_buf_inst_nxt = r_buf_inst;
        w_pc_id_nxt    = r_pc_id;
        w_inst_id_nxt  = r_inst_id;
        w_valid_id_nxt = r_valid_id;
        if (branch_en && !stall) begin
            // Redirect wins: any word accepted this cycle and the hold buffer are dropped.
            w_state_nxt    = FETCH;
            w_pc_nxt       = branch_tgt;
            w_inst_id_nxt  = NOP_INST;
            w_valid_id_nxt = 1'b0;
        end else if (r_state == HOLD) begin
            if (!stall) begin
                w_state_nxt    = FETCH;
                w_pc_id_nxt    = r_buf_pc;
                w_inst_id_nxt  = r_buf_inst;
                w_valid_id_nxt = 1'b1;
            end
        end else if (w_accept) begin
            w_pc_nxt = r_pc + 16'd2;
            if (stall) begin
                w_state_nxt    = HOLD;
                w_buf_pc_nxt   = r_pc;
                w_buf_inst_nxt = imem_data;
            end else begin
                w_pc_id_nxt    = r_pc;
                w_inst_id_nxt  = imem_data;
                w_valid_id_nxt = 1'b1;
            end
        end else if (!stall) begin
            w_inst_id_nxt  = NOP_INST;
            w_valid_id_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_buf_pc   <= 16'h0000;
            r_buf_inst <= 16'h0000;
            r_pc_id    <= 16'h0000;
            r_inst_id  <= NOP_INST;
            r_valid_id <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_buf_pc   <= w_buf_pc_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_pc_id    <= w_pc_id_nxt;
            r_inst_id  <= w_inst_id_nxt;
            r_valid_id <= w_valid_id_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level model of the fetch stage.
module tb_if_fetch;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_tgt = 16'h0000;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data;
    logic [15:0] pc_id;
    logic [15:0] inst_id;
    logic        valid_id;

    int n_chk = 0;
    int n_err = 0;

    // Memory contents: every word is its address xor a fixed pattern.
    assign imem_data = imem_addr ^ 16'hA5A5;

    if_fetch #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
        .branch_tgt(branch_tgt), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .pc_id(pc_id),
        .inst_id(inst_id), .valid_id(valid_id)
    );

    always #5 clk = ~clk;

    // Model: the PC, the IF/ID contents, and a queue of parked {pc, word} (at most one).
    logic [15:0] m_pc, m_pcid, m_inst;
    logic        m_vld;
    logic [31:0] m_park[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", {15'b0, imem_req}, {15'b0, m_park.size() == 0});
        chk("pc_id", pc_id, m_pcid);
        chk("inst_id", inst_id, m_inst);
        chk("valid_id", {15'b0, valid_id}, {15'b0, m_vld});
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_pcid = 16'h0000; m_inst = NOP; m_vld = 1'b0;
        m_park.delete();
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic br, input logic [15:0] tgt);
        logic [31:0] e;
        if (br && !st) begin
            m_pc = tgt; m_inst = NOP; m_vld = 1'b0;
            m_park.delete();
        end else if (m_park.size() != 0) begin
            if (!st) begin
                e = m_park.pop_front();
                m_pcid = e[31:16]; m_inst = e[15:0]; m_vld = 1'b1;
            end
        end else if (rdy) begin
            if (st) m_park.push_back({m_pc, m_pc ^ 16'hA5A5});
            else begin
                m_pcid = m_pc; m_inst = m_pc ^ 16'hA5A5; m_vld = 1'b1;
            end
            m_pc = m_pc + 16'd2;
        end else if (!st) begin
            m_inst = NOP; m_vld = 1'b0;
        end
    endtask

    // One clock: drive at negedge, model advances on the edge, compare at next negedge.
    task automatic cyc(input logic rdy, input logic st, input logic br, input logic [15:0] tgt);
        imem_rdy = rdy; stall = st; branch_en = br; branch_tgt = tgt;
        @(posedge clk);
        model_step(rdy, st, br, tgt);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req", {15'b0, imem_req}, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", {15'b0, valid_id}, 16'h0000);
        chk("rst_inst", inst_id, NOP);
        chk("rst_pcid", pc_id, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_held", {15'b0, imem_req}, 16'h0000);
        rst_n = 1'b1;
        #1 check_all();

        // Streaming, then 3-cycle memory wait at PC=6 region.
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        repeat (1) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        // Accept at PC=8 with a 4-cycle stall.
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        // Redirect while a fetch is accepted.
        cyc(1'b1, 1'b0, 1'b1, 16'h0040);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        // Branch under stall is ignored; then taken when unstalled.
        cyc(1'b1, 1'b1, 1'b1, 16'h0080);
        cyc(1'b1, 1'b0, 1'b1, 16'h0080);
        // Branch in HOLD with no stall discards the parked word.
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0100);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        // PC wrap and an odd target used as-is.
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFC);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0013);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        // Reset mid-HOLD.
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        async_reset();
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] t;
            t = $urandom_range(0, 7) == 0 ? 16'($urandom) : (16'($urandom) & 16'hFFFE);
            if ($urandom_range(0, 97) == 0) async_reset();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 6) == 0, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
